// File: rtl/uart_pkg.sv
// Shared constants, FSM state codes and the baud divisor helper for uart_tx_buffered.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    // Rounded-to-nearest clocks per bit.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an asynchronous active-high reset.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FullCnt = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CntOne  = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A push while full is refused even if a pop frees a slot this cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PtrOne : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 frames.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk_from_FPGA,
    input  logic       rst_from_FPGA,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       uart_tx_pin_for_FPGA
);

    localparam int unsigned Div  = baud_div(CLK_HZ, BAUD);
    localparam int unsigned CntW = $clog2(Div);
    localparam int unsigned BitW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] CntReload = CntW'(Div - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [BitW-1:0] LastBit   = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] BitOne    = BitW'(1);

    uart_state_t          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BitW-1:0]      bit_q, bit_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q;

    logic                 pop;
    logic                 tick;
    logic                 fifo_empty;
    logic [7:0]           fifo_data;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_from_FPGA),
        .rst_i   (rst_from_FPGA),
        .push_i  (wr_en),
        .pop_i   (pop),
        .data_i  (wr_data),
        .data_o  (fifo_data),
        .full_o  (full),
        .empty_o (fifo_empty)
    );

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != ST_IDLE) begin
            cnt_d = tick ? CntReload : cnt_q - CntOne;
        end
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_data;
`endif
                    cnt_d   = CntReload;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BitOne;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin and busy are computed from next state so both flops change on the same edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE) || !fifo_empty || (wr_en && !full);
    end

    always_ff @(posedge clk_from_FPGA or posedge rst_from_FPGA) begin
        if (rst_from_FPGA) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            bit_q      <= '0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign uart_tx_pin_for_FPGA = tx_q;
    assign busy                 = busy_q;
    assign overflow             = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomized self-checking bench for uart_tx_buffered with a line-decoding reference monitor.
module tb_uart_tx_buffered;

    localparam int CLK_HZ = 25_000_000;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 16;
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    localparam int FRAME  = NBITS * DIV;
    localparam int BUDGET = FRAME + 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, busy, overflow, tx;

    uart_tx_buffered #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_from_FPGA        (clk),
        .rst_from_FPGA        (rst),
        .wr_en                (wr_en),
        .wr_data              (wr_data),
        .full                 (full),
        .busy                 (busy),
        .overflow             (overflow),
        .uart_tx_pin_for_FPGA (tx)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] data;
        logic       start_b;
        logic       par_b;
        logic       stop_b;
        longint     t0;
    } frame_t;

    frame_t rxq[$];

    // Reference receiver: finds the start edge, samples every bit at its centre.
    initial begin : monitor
        bit               on;
        int               t;
        int               k;
        longint           t0;
        logic [NBITS-1:0] bits;
        frame_t           f;
        on = 1'b0;
        t  = 0;
        t0 = 0;
        bits = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                on = 1'b0;
            end else begin
                if (!on && tx === 1'b0) begin
                    on = 1'b1;
                    t  = 0;
                    t0 = cyc;
                end else if (on) begin
                    t++;
                end
                if (on && (t % DIV) == DIV / 2) begin
                    k = t / DIV;
                    bits[k] = tx;
                    if (k == NBITS - 1) begin
                        f.start_b = bits[0];
                        f.data    = bits[8:1];
`ifdef UART_TX_PARITY_EN
                        f.par_b   = bits[9];
`else
                        f.par_b   = 1'b0;
`endif
                        f.stop_b  = bits[NBITS-1];
                        f.t0      = t0;
                        rxq.push_back(f);
                        on = 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic even_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return logic'(ones % 2);
    endfunction

    task automatic write_byte(input logic [7:0] b, output longint t);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
        t       = cyc;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int c = 0;
        while (rxq.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (rxq.size() >= n);
    endtask

    task automatic wait_busy_low(input int budget, output longint t, output bit ok);
        int c = 0;
        while (busy !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (busy === 1'b0);
        t  = cyc;
    endtask

    task automatic test_reset;
        int bad = 0;
        repeat (3) @(negedge clk);
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL rst_tx got=%b exp=1", tx); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got=%b exp=0", full); end
        n_vec++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        rst = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL idle_line bad=%0d exp=0", bad); end
        n_vec++;
        if (rxq.size() != 0) begin n_err++; $display("FAIL idle_frames got=%0d exp=0", rxq.size()); end
    endtask

    task automatic test_single;
        longint tw, tl;
        bit     ok;
        frame_t f;
        rxq.delete();
        write_byte(8'h55, tw);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL s_busy got=%b exp=1", busy); end
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL s_prestart got=%b exp=1", tx); end
        wait_frames(1, BUDGET, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL s_timeout frames=%0d exp=1", rxq.size()); end
        if (ok) begin
            f = rxq[0];
            n_vec++;
            if ({f.stop_b, f.data, f.start_b} !== 10'b1010101010) begin
                n_err++;
                $display("FAIL s_bits got=%b exp=1010101010", {f.stop_b, f.data, f.start_b});
            end
            n_vec++;
            if (f.t0 != tw + 1) begin
                n_err++; $display("FAIL s_start got=%0d exp=%0d", f.t0 - tw, 1);
            end
`ifdef UART_TX_PARITY_EN
            n_vec++; if (f.par_b !== 1'b0) begin n_err++; $display("FAIL s_par got=%b exp=0", f.par_b); end
`endif
        end
        wait_busy_low(BUDGET, tl, ok);
        n_vec++;
        if (!ok || tl - tw != FRAME + 1) begin
            n_err++; $display("FAIL s_busyfall got=%0d exp=%0d ok=%0d", tl - tw, FRAME + 1, ok);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp[3];
        longint     te, tl;
        bit         ok;
        exp[0] = 8'hA3; exp[1] = 8'h0F; exp[2] = 8'hFF;
        rxq.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = exp[i];
        end
        @(negedge clk); wr_en = 1'b0;
        te = cyc - 2;
        wait_frames(3, 3 * BUDGET, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL b_timeout frames=%0d exp=3", rxq.size()); end
        for (int i = 0; i < 3 && i < rxq.size(); i++) begin
            n_vec++;
            if (rxq[i].data !== exp[i] || rxq[i].start_b !== 1'b0 || rxq[i].stop_b !== 1'b1) begin
                n_err++;
                $display("FAIL b_data%0d got=%h/%b/%b exp=%h/0/1", i, rxq[i].data,
                         rxq[i].start_b, rxq[i].stop_b, exp[i]);
            end
            n_vec++;
            if (rxq[i].t0 != te + 1 + longint'(i) * (FRAME + 1)) begin
                n_err++;
                $display("FAIL b_start%0d got=%0d exp=%0d", i, rxq[i].t0 - te,
                         1 + i * (FRAME + 1));
            end
`ifdef UART_TX_PARITY_EN
            n_vec++;
            if (rxq[i].par_b !== even_par(exp[i])) begin
                n_err++; $display("FAIL b_par%0d got=%b exp=%b", i, rxq[i].par_b, even_par(exp[i]));
            end
`endif
        end
        wait_busy_low(BUDGET, tl, ok);
    endtask

    // 18 consecutive writes against an occupancy model; one pop lands inside the burst.
    task automatic test_fill;
        logic [7:0] expq[$];
        int         occ = 0;
        bit         started = 1'b0;
        bit         exp_ovf = 1'b0;
        bit         acc, popn, ok;
        logic [7:0] b;
        longint     tl;
        rxq.delete();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            n_vec++;
            if (full !== logic'(occ == DEPTH)) begin
                n_err++; $display("FAIL f_full%0d got=%b exp=%b", i, full, occ == DEPTH);
            end
            n_vec++;
            if (overflow !== exp_ovf) begin
                n_err++; $display("FAIL f_ovf%0d got=%b exp=%b", i, overflow, exp_ovf);
            end
            b = 8'($urandom);
            wr_en = 1'b1; wr_data = b;
            acc  = (occ < DEPTH);
            popn = !started && occ > 0;
            if (acc) expq.push_back(b); else exp_ovf = 1'b1;
            occ = occ + int'(acc) - int'(popn);
            if (popn) started = 1'b1;
        end
        @(negedge clk); wr_en = 1'b0;
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL f_fullend got=%b exp=1", full); end
        n_vec++;
        if (overflow !== exp_ovf) begin
            n_err++; $display("FAIL f_ovfend got=%b exp=%b", overflow, exp_ovf);
        end
        wait_frames(expq.size(), expq.size() * BUDGET, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL f_timeout got=%0d exp=%0d", rxq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
            n_vec++;
            if (rxq[i].data !== expq[i] || rxq[i].stop_b !== 1'b1) begin
                n_err++;
                $display("FAIL f_data%0d got=%h stop=%b exp=%h", i, rxq[i].data, rxq[i].stop_b,
                         expq[i]);
            end
        end
        wait_busy_low(BUDGET, tl, ok);
        repeat (DIV * 2) @(negedge clk);
        n_vec++;
        if (rxq.size() != expq.size()) begin
            n_err++; $display("FAIL f_count got=%0d exp=%0d", rxq.size(), expq.size());
        end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL f_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_midframe;
        longint     te, tw, tl;
        bit         ok;
        logic [7:0] b;
        rxq.delete();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = (i == 0) ? 8'h00 : 8'($urandom);
        end
        @(negedge clk); wr_en = 1'b0;
        te = cyc - 16;
        while (cyc < te + 1 + 1000) @(negedge clk);
        n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL r_mid_tx got=%b exp=0", tx); end
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL r_mid_full got=%b exp=1", full); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL r_tx got=%b exp=1", tx); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL r_busy got=%b exp=0", busy); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL r_full got=%b exp=0", full); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL r_ovf got=%b exp=0", overflow); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (DIV * 2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            n_err++; $display("FAIL r_flushed busy=%b tx=%b exp=0/1", busy, tx);
        end
        rxq.delete();
        b = 8'($urandom);
        write_byte(b, tw);
        wait_frames(1, BUDGET, ok);
        n_vec++;
        if (!ok || rxq[0].data !== b || rxq[0].t0 != tw + 1 || rxq[0].stop_b !== 1'b1) begin
            n_err++; $display("FAIL r_clean ok=%0d got=%h exp=%h", ok, ok ? rxq[0].data : 8'h00, b);
        end
        wait_busy_low(BUDGET, tl, ok);
        n_vec++;
        if (!ok || tl - tw != FRAME + 1) begin
            n_err++; $display("FAIL r_busyfall got=%0d exp=%0d", tl - tw, FRAME + 1);
        end
    endtask

    task automatic test_random;
        logic [7:0] expq[$];
        longint     tf, tl;
        bit         ok;
        rxq.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'($urandom);
            expq.push_back(wr_data);
            if (i == 0) tf = cyc + 1;
            @(negedge clk); wr_en = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_frames(5, 5 * BUDGET, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL x_timeout got=%0d exp=5", rxq.size()); end
        for (int i = 0; i < 5 && i < rxq.size(); i++) begin
            n_vec++;
            if (rxq[i].data !== expq[i] || rxq[i].start_b !== 1'b0 || rxq[i].stop_b !== 1'b1) begin
                n_err++; $display("FAIL x_data%0d got=%h exp=%h", i, rxq[i].data, expq[i]);
            end
            n_vec++;
            if (rxq[i].t0 != tf + 1 + longint'(i) * (FRAME + 1)) begin
                n_err++;
                $display("FAIL x_start%0d got=%0d exp=%0d", i, rxq[i].t0 - tf, 1 + i * (FRAME + 1));
            end
`ifdef UART_TX_PARITY_EN
            n_vec++;
            if (rxq[i].par_b !== even_par(expq[i])) begin
                n_err++; $display("FAIL x_par%0d got=%b exp=%b", i, rxq[i].par_b, even_par(expq[i]));
            end
`endif
        end
        wait_busy_low(BUDGET, tl, ok);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] v[2];
        longint     tw, tl;
        bit         ok;
        v[0] = 8'h07; v[1] = 8'h03;
        for (int i = 0; i < 2; i++) begin
            rxq.delete();
            write_byte(v[i], tw);
            wait_frames(1, BUDGET, ok);
            n_vec++;
            if (!ok || rxq[0].par_b !== even_par(v[i]) || rxq[0].data !== v[i]) begin
                n_err++;
                $display("FAIL p_bit%0d got=%b exp=%b", i, ok ? rxq[0].par_b : 1'bx, even_par(v[i]));
            end
            wait_busy_low(BUDGET, tl, ok);
            n_vec++;
            if (!ok || tl - tw - 1 != 2387) begin
                n_err++; $display("FAIL p_len%0d got=%0d exp=2387", i, tl - tw - 1);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_reset_midframe();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter that drives the board's serial TX pin. It accepts bytes from the pc_one memory-mapped store path through a simple write strobe and queues them in a small FIFO. It serializes them as 8N1 frames (8E1 when parity is compiled in) at a fixed baud rate derived from the core clock. It sits between the core's MMIO decode and `uart_tx_pin_for_FPGA`, running in the divided core clock domain.

## Interface
- `CLK_HZ`, 25_000_000: frequency of `clk_from_FPGA` in Hz.
- `BAUD`, 115200: line rate. The divisor `DIV = (CLK_HZ + BAUD/2) / BAUD`, which is 217 at the defaults. `DIV` must be ≥ 2.
- `FIFO_DEPTH`, 16: byte capacity. Must be a power of 2, ≥ 2.
- `clk_from_FPGA`  input  1: core clock; all logic updates on its rising edge.
- `rst_from_FPGA`  input  1: reset, asynchronous, active-high.
- `wr_en`  input  1: byte write strobe, one byte per asserted cycle.
- `wr_data`  input  8: byte to send.
- `full`  output  1: FIFO holds `FIFO_DEPTH` bytes.
- `busy`  output  1: FIFO is non-empty or a frame is in progress.
- `overflow`  output  1: sticky flag, set when a write is dropped.
- `uart_tx_pin_for_FPGA`  output  1: serial line, idle high.

## Operation
- Reset values:
  - `uart_tx_pin_for_FPGA`=1, `full`=0, `busy`=0, `overflow`=0.
  - FIFO is empty and the FSM is in IDLE.
- Write handling:
  - A write is accepted when `wr_en`=1 and `full`=0 (registered value).
  - When `wr_en`=1 and `full`=1, the byte is dropped and `overflow` is set until reset. FIFO contents are unchanged.
  - A write and a pop in the same cycle are both performed and the count is unchanged. A write while `full`=1 is still rejected even if a pop occurs in that cycle.
- FSM states:
  - IDLE: line is high. If the FIFO is non-empty, pop the head into the shift register, load the baud counter with `DIV-1`, and go to START.
  - START: line is 0 for `DIV` cycles, then go to DATA with bit index 0.
  - DATA: line carries `shift[0]` for `DIV` cycles per bit, LSB first, for 8 bits, then go to PARITY (if enabled) or STOP.
  - PARITY: line carries the XOR of the 8 data bits (even parity) for `DIV` cycles.
  - STOP: line is 1 for `DIV` cycles, then go to IDLE.
- Baud counter: counts down from `DIV-1` to 0. A state/bit advance happens on the cycle the counter equals 0, and the counter reloads to `DIV-1`. It is $clog2(DIV) bits wide and never wraps below 0.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider to distinguish full from empty.
- `busy` = FIFO non-empty OR state ≠ IDLE. It is registered.
- Reset asserted mid-frame: the line goes high immediately (asynchronously), the frame is truncated, and queued bytes are lost.

## Timing
- `uart_tx_pin_for_FPGA` is driven directly from a flop: no combinational path to the pin, no glitches.
- Latency: for a write sampled at edge N with the FIFO empty and the FSM idle:
  - `busy`=1 after edge N.
  - The pop occurs at edge N+1, and the start bit (line=0) begins after edge N+1.
- Frame length is `10·DIV` cycles (`11·DIV` with parity), followed by exactly one IDLE cycle before the next start bit.
- Back-to-back queued bytes therefore start `10·DIV+1` cycles apart: 2171 cycles at the defaults.
- `full` and the count update on the edge that accepts the write or performs the pop.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state present; 8E1 frames of `11·DIV` cycles.
- Undefined: PARITY state and its logic are absent; 8N1 frames of `10·DIV` cycles.

## Structure
- Package `uart_pkg` holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - `DATA_BITS`=8;
  - the divisor function `baud_div(clk_hz, baud)`.
- Sub-module `sync_fifo`: single-clock FIFO parameterized on width (8) and depth. It has ports for push, pop, data in/out, full, and empty, and uses the same clock and asynchronous active-high reset.
- The top level contains the FSM, baud counter, shift register, bit index, and the overflow flag.

## Test plan
- Reset is released with no writes: line stays 1 and `busy`=0 for 5000 cycles.
- Write 0x55 once (DIV=217):
  - Start bit begins after the next edge.
  - Line samples taken at bit centres read 0,1,0,1,0,1,0,1,0,1.
  - `busy` falls 2171 cycles after the write.
- Write 0xA3, 0x0F, 0xFF in consecutive cycles: three frames decode in order, with start bits 2171 cycles apart.
- Write 17 bytes in consecutive cycles with `FIFO_DEPTH`=16:
  - `full` rises after the 16th accepted write.
  - At most one byte is popped by then.
  - The 17th byte is accepted only if a pop freed space; otherwise it is dropped and `overflow`=1.
  - The serialized stream matches the accepted bytes exactly.
- Assert reset 1000 cycles into a frame of 0x00: line goes high immediately, and `busy`, `full`, `overflow` read 0. A write after release produces a clean frame.
- With `UART_TX_PARITY_EN`:
  - 0x07 → parity bit 1; 0x03 → parity bit 0.
  - Frame length is 2387 cycles.
